// File: rtl/regfile_pkg.sv
// Shared constants, sweep state encoding and the write-priority helper
// for the multi-port register file.
package regfile_pkg;

  localparam int DEF_DW   = 32;
  localparam int DEF_NREG = 32;
  localparam int DEF_NR   = 4;
  localparam int DEF_NW   = 2;

  // Upper bound on write ports handled by the priority helper.
  localparam int WMAX = 16;

  typedef enum logic [0:0] {
    ST_SWEEP = 1'b0,
    ST_READY = 1'b1
  } sweep_state_t;

  // Given the ports hitting one register, keep only the highest-index one.
  function automatic logic [WMAX-1:0] highest_hot(input logic [WMAX-1:0] hits);
    logic [WMAX-1:0] mask;
    logic            found;
    mask  = '0;
    found = 1'b0;
    for (int j = WMAX - 1; j >= 0; j--) begin
      if (hits[j] && !found) begin
        mask[j] = 1'b1;
        found   = 1'b1;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/claim bus of the register file. Inputs are plain level signals
// sampled on the rising clock edge; there is no valid/ready handshake per
// transfer: writes and claims are accepted on every edge while ready=1 and
// silently dropped while ready=0. q/q_busy are combinational.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int NREG = DEF_NREG,
  parameter int NR   = DEF_NR,
  parameter int NW   = DEF_NW
);
  localparam int AW = $clog2(NREG);

  logic [NR*AW-1:0] rn;
  logic [NR*DW-1:0] q;
  logic [NR-1:0]    q_busy;
  logic [NW*AW-1:0] wn;
  logic [NW*DW-1:0] wd;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] cn;
  logic [NW-1:0]    ce;
  logic             ready;
  sweep_state_t     dbg_state;

  modport master (
    output rn, wn, wd, we, cn, ce,
    input  q, q_busy, ready, dbg_state
  );

  modport slave (
    input  rn, wn, wd, we, cn, ce,
    output q, q_busy, ready, dbg_state
  );

endinterface

// File: rtl/regfile_wsel.sv
// Write-port arbitration: a port wins when no higher-index enabled port
// targets the same register.
module regfile_wsel
  import regfile_pkg::*;
#(
  parameter int NW = DEF_NW,
  parameter int AW = 5
) (
  input  logic [NW*AW-1:0] wn,
  input  logic [NW-1:0]    we,
  output logic [NW-1:0]    win
);

  for (genvar i = 0; i < NW; i++) begin : g_port
    logic [WMAX-1:0] w_hits;
    logic [WMAX-1:0] w_mask;

    always_comb begin
      w_hits = '0;
      for (int j = 0; j < NW; j++) begin
        w_hits[j] = we[j] && (wn[j*AW +: AW] == wn[i*AW +: AW]);
      end
    end

    assign w_mask = highest_hot(w_hits);
    assign win[i] = w_mask[i];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with index-ordered write priority, optional
// write-to-read bypass, hardwired zero register, pending bits and a
// post-reset clearing sweep over RAM-style storage.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int NREG     = DEF_NREG,
  parameter int NR       = DEF_NR,
  parameter int NW       = DEF_NW,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         clr,
  regfile_mp_if.slave  bus
);

  localparam int            AW   = $clog2(NREG);
  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  sweep_state_t     r_state, w_state_nxt;
  logic [AW-1:0]    r_cnt, w_cnt_nxt;
  logic             w_sweep_we;
  logic             w_ready;

  logic [DW-1:0]    r_mem [NREG];
  logic [NREG-1:0]  r_busy;
  logic [NREG-1:0]  w_busy_set, w_busy_clr;

  logic [NW-1:0]    w_we_eff, w_ce_eff, w_win;

  logic [AW-1:0]    w_raddr [NR];
  logic [NR*DW-1:0] w_q;
  logic [NR-1:0]    w_qb;

  assign w_ready = (r_state == ST_READY);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_SWEEP;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sweep_we  = 1'b0;
    case (r_state)
      ST_SWEEP: begin
        w_sweep_we = 1'b1;
        w_cnt_nxt  = r_cnt + 1'b1;
        if (r_cnt == LAST) w_state_nxt = ST_READY;
      end
      default: ;
    endcase
  end

  // Writes and claims are qualified once here so arbitration, busy update
  // and bypass all agree on what counts as an accepted operation.
  always_comb begin
    w_we_eff = '0;
    w_ce_eff = '0;
    for (int i = 0; i < NW; i++) begin
      w_we_eff[i] = w_ready && bus.we[i] &&
                    !((ZERO_REG != 0) && (bus.wn[i*AW +: AW] == '0));
      w_ce_eff[i] = w_ready && bus.ce[i] &&
                    !((ZERO_REG != 0) && (bus.cn[i*AW +: AW] == '0));
    end
  end

  regfile_wsel #(
    .NW (NW),
    .AW (AW)
  ) u_wsel (
    .wn  (bus.wn),
    .we  (w_we_eff),
    .win (w_win)
  );

  // Data storage carries no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (!clr && w_sweep_we) r_mem[r_cnt] <= '0;
    for (int i = 0; i < NW; i++) begin
      if (w_win[i]) r_mem[bus.wn[i*AW +: AW]] <= bus.wd[i*DW +: DW];
    end
  end

  always_comb begin
    w_busy_set = '0;
    w_busy_clr = '0;
    for (int i = 0; i < NW; i++) begin
      if (w_ce_eff[i]) w_busy_set[bus.cn[i*AW +: AW]] = 1'b1;
      if (w_win[i])    w_busy_clr[bus.wn[i*AW +: AW]] = 1'b1;
    end
  end

  // A claim beats a write to the same register in the same cycle.
  always_ff @(posedge clk) begin
    if (clr) r_busy <= '0;
    else     r_busy <= w_busy_set | (r_busy & ~w_busy_clr);
  end

  always_comb begin
    w_q  = '0;
    w_qb = '0;
    for (int k = 0; k < NR; k++) begin
      w_raddr[k]       = bus.rn[k*AW +: AW];
      w_q[k*DW +: DW]  = r_mem[w_raddr[k]];
      w_qb[k]          = r_busy[w_raddr[k]];
      if (BYPASS != 0) begin
        for (int i = 0; i < NW; i++) begin
          if (w_win[i] && (bus.wn[i*AW +: AW] == w_raddr[k])) begin
            w_q[k*DW +: DW] = bus.wd[i*DW +: DW];
            w_qb[k]         = 1'b0;
          end
        end
      end
      if (!w_ready || ((ZERO_REG != 0) && (w_raddr[k] == '0))) begin
        w_q[k*DW +: DW] = '0;
        w_qb[k]         = 1'b0;
      end
    end
  end

  assign bus.q         = w_q;
  assign bus.q_busy    = w_qb;
  assign bus.ready     = w_ready;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypassing and a non-bypassing instance
// share one stimulus stream and are checked against hand-computed values.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW = 32, NREG = 32, NR = 4, NW = 2, AW = 5;

  logic clk;
  logic clr;
  int   n_chk;
  int   n_fail;

  regfile_mp_if #(.DW(DW), .NREG(NREG), .NR(NR), .NW(NW)) bus ();
  regfile_mp_if #(.DW(DW), .NREG(NREG), .NR(NR), .NW(NW)) bus_nb ();

  assign bus_nb.rn = bus.rn;
  assign bus_nb.wn = bus.wn;
  assign bus_nb.wd = bus.wd;
  assign bus_nb.we = bus.we;
  assign bus_nb.cn = bus.cn;
  assign bus_nb.ce = bus.ce;

  regfile_mp #(.DW(DW), .NREG(NREG), .NR(NR), .NW(NW), .ZERO_REG(1), .BYPASS(1))
    u_dut (.clk(clk), .clr(clr), .bus(bus));

  regfile_mp #(.DW(DW), .NREG(NREG), .NR(NR), .NW(NW), .ZERO_REG(1), .BYPASS(0))
    u_dut_nb (.clk(clk), .clr(clr), .bus(bus_nb));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we = '0;
    bus.ce = '0;
  endtask

  task automatic wr(input int port, input logic [AW-1:0] n, input logic [DW-1:0] d);
    bus.wn[port*AW +: AW] = n;
    bus.wd[port*DW +: DW] = d;
    bus.we[port]          = 1'b1;
  endtask

  task automatic claim(input int port, input logic [AW-1:0] n);
    bus.cn[port*AW +: AW] = n;
    bus.ce[port]          = 1'b1;
  endtask

  task automatic rd(input int port, input logic [AW-1:0] n);
    bus.rn[port*AW +: AW] = n;
  endtask

  task automatic sweep_32(input string tag);
    for (int c = 1; c <= NREG; c++) begin
      if (c == 10) wr(0, 5'd5, 32'h1234);
      else         idle();
      #1;
      if (c == 1)    check({tag, "_ready_c1"}, bus.ready, 1'b0);
      if (c == NREG) check({tag, "_ready_c32"}, bus.ready, 1'b0);
      if (c == 10)   check({tag, "_q_masked"}, bus.q[0 +: DW], 32'h0);
      step();
    end
    idle();
    #1;
    check({tag, "_ready_up"}, bus.ready, 1'b1);
    check({tag, "_state_ready"}, bus.dbg_state, ST_READY);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    clr    = 1'b1;
    bus.rn = '0;
    bus.wn = '0;
    bus.wd = '0;
    bus.we = '0;
    bus.cn = '0;
    bus.ce = '0;
    step();
    step();
    rd(0, 5'd5);
    #1;
    check("rst_ready", bus.ready, 1'b0);
    check("rst_state", bus.dbg_state, ST_SWEEP);
    check("rst_q", bus.q, '0);
    check("rst_qbusy", bus.q_busy, '0);
    clr = 1'b0;

    // reset sweep with an ignored write at cycle 10
    sweep_32("sweep");
    check("r5_after_sweep", bus.q[0 +: DW], 32'h0);
    check("r5_after_sweep_nb", bus_nb.q[0 +: DW], 32'h0);

    // write priority
    wr(0, 5'd7, 32'hAAAA);
    wr(1, 5'd7, 32'h5555);
    rd(0, 5'd7);
    #1;
    check("prio_bypass_r7", bus.q[0 +: DW], 32'h5555);
    step();
    idle();
    #1;
    check("prio_r7", bus.q[0 +: DW], 32'h5555);
    check("prio_r7_nb", bus_nb.q[0 +: DW], 32'h5555);
    wr(0, 5'd3, 32'hAAAA);
    wr(1, 5'd7, 32'h5555);
    rd(0, 5'd3);
    rd(1, 5'd7);
    step();
    idle();
    #1;
    check("par_r3", bus.q[0 +: DW], 32'hAAAA);
    check("par_r7", bus.q[DW +: DW], 32'h5555);

    // bypass vs. no bypass
    rd(0, 5'd9);
    wr(0, 5'd9, 32'hDEAD);
    #1;
    check("byp_same_cycle", bus.q[0 +: DW], 32'hDEAD);
    check("nobyp_same_cycle", bus_nb.q[0 +: DW], 32'h0);
    step();
    idle();
    #1;
    check("nobyp_next_cycle", bus_nb.q[0 +: DW], 32'hDEAD);

    // zero register
    rd(0, 5'd0);
    wr(0, 5'd0, 32'hFFFF);
    claim(0, 5'd0);
    #1;
    check("zero_q_same", bus.q[0 +: DW], 32'h0);
    step();
    idle();
    #1;
    check("zero_q", bus.q[0 +: DW], 32'h0);
    check("zero_qbusy", bus.q_busy[0], 1'b0);
    check("zero_qbusy_nb", bus_nb.q_busy[0], 1'b0);

    // scoreboard
    rd(0, 5'd4);
    claim(0, 5'd4);
    #1;
    check("claim_latency", bus.q_busy[0], 1'b0);
    step();
    idle();
    #1;
    check("claim_busy", bus.q_busy[0], 1'b1);
    check("claim_busy_nb", bus_nb.q_busy[0], 1'b1);
    wr(0, 5'd4, 32'h44);
    #1;
    check("wr_busy_byp", bus.q_busy[0], 1'b0);
    check("wr_busy_nobyp", bus_nb.q_busy[0], 1'b1);
    step();
    idle();
    #1;
    check("wr_clears_busy", bus.q_busy[0], 1'b0);
    check("wr_clears_busy_nb", bus_nb.q_busy[0], 1'b0);
    check("wr_r4_data", bus_nb.q[0 +: DW], 32'h44);
    claim(0, 5'd4);
    wr(1, 5'd4, 32'h4444);
    step();
    idle();
    #1;
    check("claim_wins_busy", bus_nb.q_busy[0], 1'b1);
    check("claim_wins_data", bus_nb.q[0 +: DW], 32'h4444);
    claim(1, 5'd12);
    rd(1, 5'd12);
    step();
    idle();
    #1;
    check("claim_p1_busy", bus.q_busy[1], 1'b1);

    // mid-sweep reset
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int c = 1; c <= 20; c++) step();
    #1;
    check("mid_ready", bus.ready, 1'b0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    rd(0, 5'd4);
    rd(1, 5'd12);
    sweep_32("resweep");
    check("resweep_busy_r4", bus.q_busy[0], 1'b0);
    check("resweep_busy_r12", bus.q_busy[1], 1'b0);
    check("resweep_busy_r4_nb", bus_nb.q_busy[0], 1'b0);
    check("resweep_r4_data", bus.q[0 +: DW], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the superscalar datapath, generalising the 2-write-port register file to NR read ports and NW write ports. It adds index-ordered write priority, an optional same-cycle write-to-read bypass, a hardwired-zero register, a per-register pending (scoreboard) bit, and a sequential clearing sweep after reset so the array can map onto RAM-style storage. It sits between the ID stage (reads, claims) and the WB stage (writes).

## Interface
- DW, 32: data width.
- NREG, 32: number of registers (power of two, ≥4).
- NR, 4: read ports.
- NW, 2: write ports (also number of claim ports).
- ZERO_REG, 1: when 1, register 0 reads as 0 and ignores writes and claims.
- BYPASS, 1: when 1, a read of a register being written this cycle returns the write data.
- AW, $clog2(NREG): derived register-number width (localparam).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clr  in  1  reset, synchronous, active-high.
- rn  in  NR*AW  read register numbers; port k in bits [k*AW +: AW].
- q  out  NR*DW  read data, combinational.
- q_busy  out  NR  pending bit of each read register, combinational.
- wn  in  NW*AW  write register numbers.
- wd  in  NW*DW  write data.
- we  in  NW  write enables.
- cn  in  NW*AW  claim register numbers (mark pending).
- ce  in  NW  claim enables.
- ready  out  1  high when the clearing sweep is complete and the file accepts writes and claims.

## Operation
- Write priority: when several enabled write ports target the same register, the highest-index port wins; lower ports to that register are dropped. Different registers are written in parallel.
- ZERO_REG=1: writes and claims to register 0 are ignored; q reads 0 and q_busy reads 0 for register 0.
- Read: q[k] = reg[rn[k]]. With BYPASS=1, if any enabled write (after priority) targets rn[k] this cycle, q[k] = winning write data instead.
- Scoreboard: busy[r] set on edge by any enabled claim to r; cleared on edge by any winning write to r. Claim and write to the same r in one cycle: claim wins (busy stays 1, data updated). q_busy[k] = busy[rn[k]], except with BYPASS=1 a same-cycle write to rn[k] forces 0.
- Sweep: clr high at an edge → cnt←0, ready←0, all busy←0. Each following edge with clr low: reg[cnt]←0, cnt←cnt+1; on the edge clearing reg[NREG-1], ready←1.
- While ready=0: writes and claims are ignored, q=0, q_busy=0.
- clr mid-sweep restarts the sweep from 0. clr held high keeps the block at cnt=0, ready=0.

## Timing
- Write latency: 1 edge. Visible on q the next cycle, or the same cycle with BYPASS=1.
- Claim latency: 1 edge.
- ready rises exactly NREG edges after the first edge at which clr is low.
- Reset values: ready=0, all busy=0, cnt=0; q and q_busy read 0 until ready=1.
- Register contents before the sweep reaches them are undefined but masked because q=0.
- No combinational path from q or q_busy to any input other than rn, wn, wd, we (bypass).

## Structure
- Package regfile_pkg: default DW/NREG/NR/NW constants and a function computing the write-winner mask per register.
- One sub-module, regfile_wsel: given wn/we, produces the per-port "winning" enables; it is shared by the array write logic, the busy clear and the bypass mux.
- Storage is a plain reg array with no reset on data, so it can infer RAM. The sweep counter and ready flag are the only reset-dependent state besides busy.

## Test plan
- Reset sweep: pulse clr 1 cycle with NREG=32 → ready=0 for 32 cycles, rises on the 32nd edge. A write of 0x1234 to r5 at cycle 10 is ignored, and r5 reads 0 after ready.
- Priority: we=2'b11, wn0=wn1=7, wd0=0xAAAA, wd1=0x5555 → r7=0x5555 next cycle. With wn0=3 instead, r3=0xAAAA and r7=0x5555.
- Bypass: BYPASS=1, rn0=9, write 0xDEAD to r9 → q0=0xDEAD in the same cycle. BYPASS=0 → old value that cycle, 0xDEAD the next.
- Zero register: write 0xFFFF to r0 and claim r0 → q reads 0 and q_busy reads 0.
- Scoreboard: claim r4 → q_busy=1 next cycle. Write r4 → 0 after the edge. Claim and write r4 in the same cycle → busy stays 1 and the data is updated.
- Mid-sweep reset: assert clr at sweep cycle 20 → cnt restarts. ready rises 32 edges after clr falls, and busy bits set before the reset read 0.
